// File: rtl/btn_event_arbiter.sv
// Round-robin arbiter that turns debounced button press ticks into single valid/ready commands.
// Optional auto-repeat for held buttons is compiled in with `define BTN_REPEAT_EN.
module btn_event_arbiter #(
  parameter int N_BTN         = 4,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         i_btn_tick,
  input  logic [N_BTN-1:0]         i_btn_level,
  output logic                     o_cmd_valid,
  output logic [$clog2(N_BTN)-1:0] o_cmd_id,
  output logic                     o_cmd_repeat,
  input  logic                     i_cmd_ready,
  output logic                     o_drop,
  output logic [7:0]               o_drop_cnt,
  output logic                     dbg_state,
  output logic [$clog2(N_BTN)-1:0] dbg_ptr,
  output logic [N_BTN-1:0]         dbg_pend
);

  localparam int IW = $clog2(N_BTN);

  // Handshake: a command transfers on a clk edge where o_cmd_valid=1 and
  // i_cmd_ready=1; id/repeat are held stable until then, and ready is a
  // don't-care whenever valid is 0.

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     cmd_id_q;
  logic [N_BTN-1:0]  pend_q, pend_d;
  logic [N_BTN-1:0]  acc_vec;
  logic [N_BTN-1:0]  rep_evt;
  logic              accept;
  logic              any_pend;
  logic              grant_load;
  logic [IW-1:0]     gnt;
  logic              drop_any;
  logic              drop_q;
  logic [7:0]        drop_cnt_q;

  assign accept     = (state_q == ISSUE) && i_cmd_ready;
  assign any_pend   = |pend_q;
  assign grant_load = (state_q == IDLE) && any_pend;

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      acc_vec[i] = accept && (cmd_id_q == IW'(i));
    end
  end

  // First pending button at or after ptr, wrapping modulo N_BTN.
  always_comb begin
    logic found;
    int   idx;
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int k = 0; k < N_BTN; k++) begin
      idx = (int'(ptr_q) + k) % N_BTN;
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        gnt   = IW'(idx);
      end
    end
  end

  // A tick landing on its own accept edge re-arms the request instead of dropping.
  always_comb begin
    pend_d   = pend_q;
    drop_any = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      if (acc_vec[i]) pend_d[i] = 1'b0;
      if (rep_evt[i] && !pend_q[i]) pend_d[i] = 1'b1;
      if (i_btn_tick[i]) begin
        pend_d[i] = 1'b1;
        if (pend_q[i] && !acc_vec[i]) drop_any = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_pend) state_d = ISSUE;
      ISSUE:   if (i_cmd_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q     <= '0;
      ptr_q      <= '0;
      cmd_id_q   <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      pend_q <= pend_d;
      drop_q <= drop_any;
      if (drop_any && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
      if (grant_load) cmd_id_q <= gnt;
      if (accept) begin
        if (cmd_id_q == IW'(N_BTN - 1)) ptr_q <= '0;
        else                            ptr_q <= cmd_id_q + 1'b1;
      end
    end
  end

`ifdef BTN_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW   = $clog2(RMAX + 1);

  logic [CW-1:0]    hold_cnt [N_BTN];
  logic [CW-1:0]    hold_inc [N_BTN];
  logic [N_BTN-1:0] hold_phase;
  logic [N_BTN-1:0] rep_q;
  logic             cmd_repeat_q;

  // hold_phase=0 waits out the initial delay, then each period re-fires.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      hold_inc[i] = hold_cnt[i] + 1'b1;
      rep_evt[i]  = i_btn_level[i] &&
                    (hold_phase[i] ? (hold_inc[i] == CW'(REPEAT_PERIOD))
                                   : (hold_inc[i] == CW'(REPEAT_DELAY)));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_BTN; i++) hold_cnt[i] <= '0;
      hold_phase   <= '0;
      rep_q        <= '0;
      cmd_repeat_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (!i_btn_level[i]) begin
          hold_cnt[i]   <= '0;
          hold_phase[i] <= 1'b0;
        end else if (rep_evt[i]) begin
          hold_cnt[i]   <= '0;
          hold_phase[i] <= 1'b1;
        end else begin
          hold_cnt[i]   <= hold_inc[i];
        end
        if (acc_vec[i]) rep_q[i] <= 1'b0;
        if (rep_evt[i] && !pend_q[i]) rep_q[i] <= 1'b1;
        if (i_btn_tick[i]) rep_q[i] <= 1'b0;
      end
      if (grant_load) cmd_repeat_q <= rep_q[gnt];
    end
  end

  assign o_cmd_repeat = cmd_repeat_q;
`else
  logic unused_level;
  assign unused_level = &{1'b0, i_btn_level};
  assign rep_evt      = '0;
  assign o_cmd_repeat = 1'b0;
`endif

  assign o_cmd_valid = (state_q == ISSUE);
  assign o_cmd_id    = cmd_id_q;
  assign o_drop      = drop_q;
  assign o_drop_cnt  = drop_cnt_q;
  assign dbg_state   = state_q;
  assign dbg_ptr     = ptr_q;
  assign dbg_pend    = pend_q;

endmodule

// File: doc/btn_event_arbiter.md
Name: btn_event_arbiter

Overview:
- Collects one-cycle debounced press ticks from N button debouncers.
- Holds one pending request per button.
- Round-robin arbitrates the requests onto a single valid/ready command channel. The consumer is the stopwatch control FSM or the UART TX FIFO write side.
- Counts presses lost because a request was already pending, and can optionally synthesise auto-repeat events for held buttons.

Parameters:
- N_BTN, 4, number of button requesters (2..8).
- REPEAT_DELAY, 50_000_000, clk cycles a level must be held before the first repeat (used only with BTN_REPEAT_EN).
- REPEAT_PERIOD, 10_000_000, clk cycles between subsequent repeats (used only with BTN_REPEAT_EN).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset; asserting it (0) clears all state immediately.
- i_btn_tick  in  N_BTN  one-clk press pulses from the debouncers, bit i = button i.
- i_btn_level  in  N_BTN  debounced button levels; used only with BTN_REPEAT_EN, ignored otherwise.
- o_cmd_valid  out  1  command available.
- o_cmd_id  out  $clog2(N_BTN)  index of the granted button.
- o_cmd_repeat  out  1  1 = command came from auto-repeat, 0 = from a press tick.
- i_cmd_ready  in  1  consumer accepts the command.
- o_drop  out  1  one-clk pulse, a press was lost this cycle.
- o_drop_cnt  out  8  saturating count of lost presses.

Behaviour:
- Reset values: o_cmd_valid=0, o_cmd_id=0, o_cmd_repeat=0, o_drop=0, o_drop_cnt=0, all pending bits=0, rr pointer=0, FSM=IDLE.
- Pending: pend[i] sets at the clk edge where i_btn_tick[i]=1. pend[i] clears at the accept edge of a grant to i.
- Tick on button i at its own accept edge: pend[i] stays 1 (new event). This is not a drop.
- Drop: tick on i while pend[i]=1 and no accept of i in that cycle. Then o_drop=1 for one cycle and o_drop_cnt increments, saturating at 255. Several drops in one cycle count as one.
- FSM IDLE: if any pend bit is set, grant the first set bit searching ptr, ptr+1, ... modulo N_BTN. Go to ISSUE with o_cmd_valid=1 and o_cmd_id=grant.
- Latency: tick registered at edge k gives o_cmd_valid=1 after edge k+1.
- FSM ISSUE: o_cmd_valid, o_cmd_id and o_cmd_repeat stay constant until the cycle where i_cmd_ready=1 (accept edge).
  - At the accept edge: pend[grant] clears (unless re-ticked), ptr=(grant+1) mod N_BTN, o_cmd_valid=0, FSM goes to IDLE.
  - There is one mandatory idle cycle between commands, so the maximum rate is 1 command per 2 clk.
- i_cmd_ready while o_cmd_valid=0 is ignored.
- A new higher-priority request arriving during ISSUE never changes the held grant.
- ptr advances only on accept, never on request arrival.
- Reset asserted mid-ISSUE: valid drops asynchronously and every pending request and the drop count are lost.

Optional Feature:
- Macro: BTN_REPEAT_EN.
- Defined:
  - Each button has a hold counter, 0 while i_btn_level[i]=0.
  - After REPEAT_DELAY cycles of continuous level 1, a repeat event is raised. Further events follow every REPEAT_PERIOD cycles while the level stays 1.
  - A repeat event sets pend[i] and a per-button rep[i] flag. A real tick on the same cycle clears rep[i].
  - A repeat event on an already pending button is silently discarded: no o_drop, no count.
  - o_cmd_repeat = rep[grant], latched at grant.
- Not defined: no hold counters, i_btn_level unused, o_cmd_repeat tied 0.

Test Plan:
- Reset, then single tick on btn2 with i_cmd_ready=1 -> o_cmd_valid=1, id=2 exactly 1 cycle after the tick edge. Accepted next edge, then valid=0 and ptr=3.
- Ticks on btn0,1,3 in the same cycle, ready=1 constantly, ptr=0 -> ids 0,1,3 in order, each valid for 1 cycle with 1 idle cycle between.
- ready=0 for 20 cycles while valid id=1, btn0 ticks meanwhile -> id stays 1 for all 20 cycles. After accept, next grant is 0 (ptr=2 wraps to 0).
- btn3 ticked 3 times while pend[3]=1 and ready=0 -> three o_drop pulses, o_drop_cnt=3. Then 260 extra drops -> o_drop_cnt=255.
- Tick on btn1 exactly at the accept edge of id=1 -> a second command id=1 is issued, o_drop stays 0.
- BTN_REPEAT_EN with REPEAT_DELAY=100, REPEAT_PERIOD=20: btn0 level high for 160 cycles with ready=1 -> repeats at hold cycles 100, 120, 140, 160 with o_cmd_repeat=1. Release stops repeats. rst=0 mid-hold clears everything.
